// File: rtl/pipe_stall_controller.sv
// pipe_stall_controller: ID-stage interlock sequencer for the 5-stage pipeline.
// Optional statistics counters are enabled with the STALL_STATS_EN macro.
//
// Ports:
//   clk, rst           pipeline clock, synchronous active-high reset
//   Rs, Rt             source registers of the instruction in ID
//   IsBranchID         ID instruction is a branch resolved in ID
//   BranchTaken        ID branch resolved taken this cycle
//   MemReadID2EX       EX-stage instruction is a load
//   RegWriteID2EX      EX-stage instruction writes a register
//   DestID2EX          EX-stage destination register
//   MemReadEX2MEM      MEM-stage instruction is a load
//   DestEX2MEM         MEM-stage destination register
//   Hold               external freeze
//   PCWrite, IFIDWrite load enables for PC and IF/ID
//   NoOp               inject a bubble into ID/EX
//   IFFlush            clear IF/ID
//   Busy               a multi-cycle stall is in progress
//   stall_cycles, flush_count (STALL_STATS_EN only) saturating statistics
module pipe_stall_controller #(
    parameter int MAX_STALL = 2,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs,
    input  logic [4:0] Rt,
    input  logic       IsBranchID,
    input  logic       BranchTaken,
    input  logic       MemReadID2EX,
    input  logic       RegWriteID2EX,
    input  logic [4:0] DestID2EX,
    input  logic       MemReadEX2MEM,
    input  logic [4:0] DestEX2MEM,
    input  logic       Hold,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       NoOp,
    output logic       IFFlush,
    output logic       Busy
`ifdef STALL_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam int RW = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

    // One-hot encoding so a corrupted state is detectable and recovers.
    typedef enum logic [1:0] {
        RUN   = 2'b01,
        STALL = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [RW-1:0] rem;
    logic [RW-1:0] rem_nx;
    logic [RW-1:0] need;
    logic          m_ex;
    logic          m_mem;
    int            need_raw;

    assign m_ex  = ((Rs == DestID2EX) && (Rs != 5'd0)) ||
                   ((Rt == DestID2EX) && (Rt != 5'd0));
    assign m_mem = ((Rs == DestEX2MEM) && (Rs != 5'd0)) ||
                   ((Rt == DestEX2MEM) && (Rt != 5'd0));

    // Bubbles needed: maximum over every hazard that applies, clamped.
    always_comb begin
        need_raw = 0;
        if (MemReadID2EX && m_ex)
            need_raw = 1;
        if (IsBranchID && RegWriteID2EX && !MemReadID2EX && m_ex)
            need_raw = 1;
        if (IsBranchID && MemReadEX2MEM && m_mem)
            need_raw = 1;
        if (IsBranchID && MemReadID2EX && m_ex)
            need_raw = 2;
        if (need_raw > MAX_STALL)
            need = RW'(MAX_STALL);
        else
            need = RW'(need_raw);
    end

    always_comb begin
        state_nx  = state;
        rem_nx    = rem;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        NoOp      = 1'b0;
        IFFlush   = 1'b0;
        Busy      = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (Hold) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                    end else if (need != '0) begin
                        // First bubble goes out in the detection cycle.
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        NoOp      = 1'b1;
                        rem_nx    = need - RW'(1);
                        state_nx  = (need > RW'(1)) ? STALL : RUN;
                    end else begin
                        IFFlush = BranchTaken;
                    end
                end
                STALL: begin
                    Busy      = 1'b1;
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    if (!Hold) begin
                        NoOp = 1'b1;
                        if (rem <= RW'(1)) begin
                            rem_nx   = '0;
                            state_nx = RUN;
                        end else begin
                            rem_nx = rem - RW'(1);
                        end
                    end
                end
                default: begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    rem_nx    = '0;
                    state_nx  = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            rem   <= '0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
        end
    end

`ifdef STALL_STATS_EN
    // NoOp and IFFlush are never high under Hold, so Hold needs no gating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (NoOp && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (IFFlush && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end
`endif

endmodule
